nx_ram_1rw_init: RTL

Parametrised single-port RAM: one read or write per cycle, per-bit write enable, configurable read latency.
Adds a hardware initialisation engine that clears every entry after reset or on request, with a ready handshake and a sticky access-error flag.
Drop-in successor for single-port buffer RAMs in the compression/crypto datapaths, where software cannot pre-clear memory.

---
 rtl/nx_ram_1rw_init_if.sv | 30 +++
 rtl/nx_ram_1rw_init.sv | 134 +++++++++++++
 2 files changed

// File: rtl/nx_ram_1rw_init_if.sv
// Purpose : access bundle for nx_ram_1rw_init (init control, access request, read return, error flag).
// Latency : none; wires only.
// Backpressure: none; init_done is the only readiness indication and there is no stall path.
// Ports   : master drives init_req/cs/we/add/din/bwe/err_clr; slave drives init_done/dout/dout_vld/access_err.
interface nx_ram_1rw_init_if #(
    parameter int WIDTH  = 38,
    parameter int AWIDTH = 14
);
    logic              init_req;
    logic              init_done;
    logic              cs;
    logic              we;
    logic [AWIDTH-1:0] add;
    logic [WIDTH-1:0]  din;
    logic [WIDTH-1:0]  bwe;
    logic [WIDTH-1:0]  dout;
    logic              dout_vld;
    logic              access_err;
    logic              err_clr;

    modport master (
        output init_req, cs, we, add, din, bwe, err_clr,
        input  init_done, dout, dout_vld, access_err
    );

    modport slave (
        input  init_req, cs, we, add, din, bwe, err_clr,
        output init_done, dout, dout_vld, access_err
    );
endinterface

// File: rtl/nx_ram_1rw_init.sv
// Purpose : single-port RAM, per-bit write enable, with a hardware sweep that writes INIT_VALUE to every entry.
// Latency : read (and write echo when WR_RDATA=1) returns on dout/dout_vld RD_LAT cycles after the cs cycle.
// Backpressure: none; one access per cycle when init_done=1, otherwise the access is dropped and flagged.
// Ports   : clk, rst (sync, active-high), bus (slave side of nx_ram_1rw_init_if).
module nx_ram_1rw_init #(
    parameter int                WIDTH      = 38,
    parameter int                DEPTH      = 16384,
    parameter int                AWIDTH     = $clog2(DEPTH),
    parameter int                RD_LAT     = 1,
    parameter bit                WR_RDATA   = 1'b1,
    parameter logic [WIDTH-1:0]  INIT_VALUE = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    nx_ram_1rw_init_if.slave     bus
);

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q;
    logic [AWIDTH-1:0] init_addr_q;
    logic              access_err_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              init_done;
    logic              add_ok;
    logic              err_set;
    logic              acc_fire;
    logic              in_vld;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  merged;
    logic [WIDTH-1:0]  in_dat;

    // Return pipeline: stage k register holds the result k+1 cycles after issue.
    logic [RD_LAT-1:0] vld_q;
    logic [WIDTH-1:0]  dat_q [RD_LAT];
    logic [RD_LAT-1:0] chain_vld;
    logic [WIDTH-1:0]  chain_dat [RD_LAT];

    assign init_done = (state_q == ST_READY);

    // Compare one bit wider so DEPTH itself is representable for power-of-two depths.
    assign add_ok = ({1'b0, bus.add} < (AWIDTH+1)'(DEPTH));

    // init_req has priority over a same-cycle access; the access is dropped and flagged.
    assign err_set  = bus.cs & (~init_done | ~add_ok | bus.init_req);
    assign acc_fire = bus.cs & init_done & add_ok & ~bus.init_req;

    assign rd_word = mem[bus.add];
    assign merged  = (rd_word & ~bus.bwe) | (bus.din & bus.bwe);
    assign in_vld  = acc_fire & (~bus.we | WR_RDATA);
    assign in_dat  = bus.we ? merged : rd_word;

    always_comb begin
        chain_vld    = '0;
        chain_vld[0] = in_vld;
        chain_dat[0] = in_dat;
        for (int k = 1; k < RD_LAT; k++) begin
            chain_vld[k] = vld_q[k-1];
            chain_dat[k] = dat_q[k-1];
        end
    end

    // Data stages only load on a valid entry, so the last stage (dout) holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RD_LAT; k++) begin
                vld_q[k] <= chain_vld[k];
                if (chain_vld[k]) begin
                    dat_q[k] <= chain_dat[k];
                end
            end
        end
    end

    // Storage has no reset of its own; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem[init_addr_q] <= INIT_VALUE;
            end else if (acc_fire && bus.we) begin
                mem[bus.add] <= merged;
            end
        end
    end

    // The sweep stops at DEPTH-1 so non-power-of-two depths never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_addr_q == AWIDTH'(DEPTH - 1)) begin
                        state_q <= ST_READY;
                    end else begin
                        init_addr_q <= init_addr_q + 1'b1;
                    end
                end
                default: begin
                    if (bus.init_req) begin
                        state_q     <= ST_INIT;
                        init_addr_q <= '0;
                    end
                end
            endcase
        end
    end

    // A new error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            access_err_q <= 1'b0;
        end else if (err_set) begin
            access_err_q <= 1'b1;
        end else if (bus.err_clr) begin
            access_err_q <= 1'b0;
        end
    end

    assign bus.init_done  = init_done;
    assign bus.dout       = dat_q[RD_LAT-1];
    assign bus.dout_vld   = vld_q[RD_LAT-1];
    assign bus.access_err = access_err_q;

endmodule
